// File: rtl/gps_tab_arb.sv
// Two-requester burst arbiter for the shared GPS trig lookup table.
// Grants one burst at a time, streams its beats from the ROM and flags completion.
module gps_tab_arb (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [6:0]   addr0,
    input  logic [2:0]   len0,
    input  logic         req1,
    input  logic [6:0]   addr1,
    input  logic [2:0]   len1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rom_en,
    output logic [6:0]   rom_addr,
    input  logic [127:0] rom_data,
    output logic         rd_valid,
    output logic         rd_id,
    output logic [2:0]   rd_beat,
    output logic [127:0] rd_data,
    output logic         done0,
    output logic         done1,
    output logic         busy
);

    localparam int unsigned AW = 7;
    localparam int unsigned LW = 3;
    localparam int unsigned DW = 128;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

    state_e          state_q, state_d;
    logic            id_q, id_d;
    logic [AW-1:0]   base_q, base_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   beat_q, beat_d;
    logic            last_q, last_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            rom_en_q, rom_en_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            rd_valid_q, rd_valid_d;
    logic            rd_id_q, rd_id_d;
    logic [LW-1:0]   rd_beat_q, rd_beat_d;
    logic            done0_q, done0_d;
    logic            done1_q, done1_d;
    logic            busy_q, busy_d;
    logic            win;
    logic            last_beat;

    // Next-state, capture and registered-output computation
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        base_d     = base_q;
        len_d      = len_q;
        beat_d     = beat_q;
        last_d     = last_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rom_en_d   = 1'b0;
        rom_addr_d = '0;
        win        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the requester not granted last wins
                    win        = (req0 && req1) ? ~last_q : req1;
                    state_d    = BURST;
                    id_d       = win;
                    base_d     = win ? addr1 : addr0;
                    len_d      = win ? len1 : len0;
                    beat_d     = '0;
                    last_d     = win;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    rom_en_d   = 1'b1;
                    rom_addr_d = win ? addr1 : addr0;
                end
            end
            BURST: begin
                if (beat_q == len_q) begin
                    state_d = DRAIN;
                end else begin
                    beat_d     = beat_q + LW'(1);
                    rom_en_d   = 1'b1;
                    rom_addr_d = base_q + AW'(beat_d);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        last_beat  = rom_en_q && (beat_q == len_q);
        rd_valid_d = rom_en_q;
        rd_id_d    = id_q;
        rd_beat_d  = beat_q;
        done0_d    = last_beat && !id_q;
        done1_d    = last_beat && id_q;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            last_q     <= 1'b1;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_beat_q  <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            base_q     <= base_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            last_q     <= last_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_beat_q  <= rd_beat_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_id    = rd_id_q;
    assign rd_beat  = rd_beat_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;

    // ROM data arrives the cycle after the read strobe, aligned with rd_valid
    assign rd_data  = rd_valid_q ? rom_data : DW'(0);

endmodule
